// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding and default sizing.
package mem_arbiter_pkg;

    localparam int unsigned ARB_STARVE_LIMIT = 3;
    localparam int unsigned ARB_ADDR_W       = 32;
    localparam int unsigned ARB_DATA_W       = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory port of the arbiter.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the memory, seen from outside the arbiter
    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

    // The arbiter's own view
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

endinterface

// File: rtl/arb_priority.sv
// Grant decision: data normally wins, a waiting fetch wins once it has been starved long enough.
module arb_priority import mem_arbiter_pkg::*; #(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_if,
    output logic             grant_d
);

    logic starved;

    assign starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_if = if_req & (~d_req | starved);
    assign grant_d  = d_req & ~grant_if;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of a single-port memory
// with registered memory request and registered responses.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int unsigned ADDR_W       = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant_if;
    logic              grant_d;

    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] d_rdata_q;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_priority (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_cnt (starve_cnt),
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE; RESP always returns to IDLE after its pulse
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_nxt = IF_BUSY;
                end else if (grant_d) begin
                    state_nxt = D_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request, response capture and starvation bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            starve_cnt  <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        starve_cnt  <= '0;
                    end else if (grant_d) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        if (bus.if_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                IF_BUSY: begin
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if_rdata_q  <= bus.mem_rdata;
                        if_ready_q  <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        d_rdata_q   <= bus.mem_rdata;
                        d_ready_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random fetch/data traffic checked by a scoreboard.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory responder: random or fixed wait states, optional stray acks while idle
    logic [31:0] mem_store [logic [31:0]];
    bit tie_mode   = 1'b1;
    bit stray_en   = 1'b0;
    int fixed_wait = -1;
    int wcnt       = 0;
    bit busy_r     = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : rom(a);
    endfunction

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (tie_mode) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hDEADBEEF;
            end else if (bus.mem_valid) begin
                if (!busy_r) begin
                    busy_r = 1'b1;
                    wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 4));
                end
                if (wcnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_rd(bus.mem_addr);
                    if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
                    busy_r = 1'b0;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    wcnt--;
                end
            end else begin
                busy_r = 1'b0;
                bus.mem_ready = stray_en && ($urandom_range(0, 2) == 0);
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Reference: requester-level expectations and the arbitration rule on a transaction timeline
    typedef enum int {P_IDLE, P_BUSY, P_RESP} ph_t;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    bit          grant_log[$];
    ph_t         ph = P_IDLE;
    bit          mon_en = 1'b0;
    int          starve = 0;
    int          valid_cycles = 0;
    bit          who_if;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, last_if, last_d, e_data;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_valid) valid_cycles++;
            case (ph)
                P_IDLE: begin
                    chk("idle_mem_valid", 32'(bus.mem_valid), 0);
                    chk("idle_if_ready", 32'(bus.if_ready), 0);
                    chk("idle_d_ready", 32'(bus.d_ready), 0);
                    chk("hold_if_rdata", bus.if_rdata, last_if);
                    chk("hold_d_rdata", bus.d_rdata, last_d);
                    if (bus.if_req || bus.d_req) begin
                        who_if = bus.if_req && (!bus.d_req || starve == LIMIT);
                        if (who_if) begin
                            starve = 0;
                            e_addr = bus.if_addr;
                            e_we   = 1'b0;
                        end else begin
                            if (bus.if_req && starve < LIMIT) starve++;
                            e_addr  = bus.d_addr;
                            e_we    = bus.d_we;
                            e_wdata = bus.d_wdata;
                        end
                        grant_log.push_back(who_if);
                        ph = P_BUSY;
                    end
                end
                P_BUSY: begin
                    chk("busy_mem_valid", 32'(bus.mem_valid), 1);
                    chk("busy_mem_addr", bus.mem_addr, e_addr);
                    chk("busy_mem_we", 32'(bus.mem_we), 32'(e_we));
                    if (e_we) chk("busy_mem_wdata", bus.mem_wdata, e_wdata);
                    chk("busy_if_ready", 32'(bus.if_ready), 0);
                    chk("busy_d_ready", 32'(bus.d_ready), 0);
                    chk("hold_if_rdata", bus.if_rdata, last_if);
                    chk("hold_d_rdata", bus.d_rdata, last_d);
                    if (bus.mem_ready) ph = P_RESP;
                end
                default: begin
                    chk("resp_mem_valid", 32'(bus.mem_valid), 0);
                    chk("resp_if_ready", 32'(bus.if_ready), 32'(who_if));
                    chk("resp_d_ready", 32'(bus.d_ready), 32'(!who_if));
                    if (who_if) begin
                        if (exp_if_q.size() == 0) chk("if_unexpected_resp", 1, 0);
                        else begin
                            e_data = exp_if_q.pop_front();
                            chk("resp_if_rdata", bus.if_rdata, e_data);
                            last_if = e_data;
                        end
                        chk("hold_d_rdata", bus.d_rdata, last_d);
                    end else begin
                        if (exp_d_q.size() == 0) chk("d_unexpected_resp", 1, 0);
                        else begin
                            e_data = exp_d_q.pop_front();
                            chk("resp_d_rdata", bus.d_rdata, e_data);
                            last_d = e_data;
                        end
                        chk("hold_if_rdata", bus.if_rdata, last_if);
                    end
                    ph = P_IDLE;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit is_if, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (is_if ? bus.if_ready : bus.d_ready) break;
            lat++;
            if (lat > 200) begin
                chk(is_if ? "if_ready_timeout" : "d_ready_timeout", 0, 1);
                break;
            end
        end
        step();
    endtask

    task automatic do_fetch(input logic [31:0] addr, output int lat);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        exp_if_q.push_back(rom(addr));
        wait_rdy(1'b1, lat);
        bus.if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int lat;
        logic [31:0] old;
        old = ref_mem.exists(addr) ? ref_mem[addr] : rom(addr);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        exp_d_q.push_back(old);
        if (we) ref_mem[addr] = wdata;
        wait_rdy(1'b0, lat);
        bus.d_req = 1'b0;
    endtask

    task automatic check_log(input string name, input bit exp_seq[$]);
        chk({name, "_len"}, grant_log.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
            chk(name, 32'(grant_log[i]), 32'(exp_seq[i]));
    endtask

    initial begin
        int lat_a, lat_b;
        bit seen;
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_mem_valid", 32'(bus.mem_valid), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_ready", 32'(bus.if_ready), 0);
        chk("rst_d_ready", 32'(bus.d_ready), 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);

        // Fetch alone, memory tied ready, first grant right after reset release
        step();
        reset = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(negedge clk);
        chk("f0_mem_valid", 32'(bus.mem_valid), 0);
        step(); @(negedge clk);
        chk("f1_mem_valid", 32'(bus.mem_valid), 1);
        chk("f1_mem_we", 32'(bus.mem_we), 0);
        chk("f1_mem_addr", bus.mem_addr, 32'h10);
        chk("f1_if_ready", 32'(bus.if_ready), 0);
        step(); @(negedge clk);
        chk("f2_if_ready", 32'(bus.if_ready), 1);
        chk("f2_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("f2_mem_valid", 32'(bus.mem_valid), 0);
        step();
        bus.if_req = 1'b0;
        tie_mode = 1'b0;
        @(negedge clk);
        chk("f3_if_ready", 32'(bus.if_ready), 0);
        step();
        last_if = 32'hDEADBEEF; last_d = '0; ph = P_IDLE; starve = 0;
        mon_en = 1'b1;

        // Collision: data first, then fetch
        grant_log.delete();
        fork
            do_data(1'b1, 32'h20, 32'h55);
            do_fetch(32'h100, lat_a);
        join
        check_log("collision_order", '{1'b0, 1'b1});

        // Starvation: continuous data stream with a waiting fetch
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) do_data(1'b1, 32'h1000 + 32'(i) * 32'd4, $urandom);
            end
            do_fetch(32'h104, lat_b);
        join
        check_log("starve_order", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        // Wait states: 5 low cycles of mem_ready
        repeat (2) step();
        fixed_wait = 5; valid_cycles = 0;
        do_fetch(32'h108, lat_a);
        chk("wait_latency", lat_a, 7);
        chk("wait_valid_cycles", valid_cycles, 6);
        fixed_wait = -1;

        // Requester drops its request right after it is sampled
        repeat (2) step();
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        exp_if_q.push_back(rom(32'h180));
        step();
        bus.if_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.if_ready;
        end
        chk("drop_ready_seen", 32'(seen), 1);
        repeat (2) step();

        // Random mixed traffic with stray acks
        stray_en = 1'b1;
        fork
            begin
                int l;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    do_fetch(32'h100 + 32'($urandom_range(0, 63)) * 32'd4, l);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    do_data(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4, $urandom);
                end
            end
        join
        repeat (4) step();
        chk("if_queue_drained", exp_if_q.size(), 0);
        chk("d_queue_drained", exp_d_q.size(), 0);

        // Reset in the middle of a data access
        mon_en = 1'b0; stray_en = 1'b0; fixed_wait = 100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1004;
        step(); @(negedge clk);
        chk("rstmid_busy_valid", 32'(bus.mem_valid), 1);
        step();
        reset = 1'b1; bus.d_req = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_valid", 32'(bus.mem_valid), 0);
        chk("rstmid_mem_addr", bus.mem_addr, 0);
        chk("rstmid_d_rdata", bus.d_rdata, 0);
        chk("rstmid_if_rdata", bus.if_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rstmid_no_d_ready", 32'(bus.d_ready), 0);
            @(negedge clk);
        end
        step();
        fixed_wait = 0; last_if = '0; last_d = '0; ph = P_IDLE; starve = 0;
        exp_if_q.delete(); exp_d_q.delete();
        mon_en = 1'b1;
        do_fetch(32'h140, lat_a);
        chk("rstmid_fetch_latency", lat_a, 2);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
